keypad_encoder: RTL and testbench

Converts the microwave's 10-key numeric keypad into a debounced BCD digit plus a single active-low load strobe for the downstream time-entry register. It also generates the slow `pgt_1hz` timebase used by the countdown logic. It sits between the keypad inputs and the timer/control path of the microwave controller.

---
 rtl/keypad_encoder_pkg.sv | 35 +++
 rtl/keypad_encoder_clk_divider.sv | 28 ++
 rtl/keypad_encoder.sv | 94 +++++++++
 tb/tb_keypad_encoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_encoder_pkg.sv
// Shared types and helpers for the keypad encoder.
// FSM states plus one-hot validity and one-hot to BCD encoding.
package keypad_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        LOAD,
        WAIT_RELEASE
    } state_t;

    function automatic logic onehot_valid(input logic [9:0] k);
        return (k != '0) && ((k & (k - 10'd1)) == '0);
    endfunction

    function automatic logic [3:0] encode(input logic [9:0] k);
        logic [3:0] r;
        r = '0;
        unique case (1'b1)
            k[0]: r = 4'd0;
            k[1]: r = 4'd1;
            k[2]: r = 4'd2;
            k[3]: r = 4'd3;
            k[4]: r = 4'd4;
            k[5]: r = 4'd5;
            k[6]: r = 4'd6;
            k[7]: r = 4'd7;
            k[8]: r = 4'd8;
            k[9]: r = 4'd9;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_encoder_clk_divider.sv
// Square-wave timebase: toggles pgt_1hz every HALF_PERIOD clocks.
// Free-running, only reset affects it.
module clk_divider #(
    parameter int HALF_PERIOD = 50
) (
    input  logic clk,
    input  logic rst,
    output logic pgt_1hz
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pgt_1hz <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            pgt_1hz <= ~pgt_1hz;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// Debounced keypad to BCD encoder with active-low load strobe.
// Also hosts the slow countdown timebase.
import keypad_encoder_pkg::*;

module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HALF_PERIOD     = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] keypad,
    input  logic       enablen,
    output logic [3:0] bcd_output,
    output logic       loadn,
    output logic       pgt_1hz
);

    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [9:0]    sync1;
    logic [9:0]    ks;
    logic [9:0]    cand;
    logic [9:0]    cand_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [3:0]    bcd_n;
    logic          loadn_n;
    state_t        state;
    state_t        state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            ks         <= '0;
            state      <= IDLE;
            cand       <= '0;
            cnt        <= '0;
            bcd_output <= '0;
            loadn      <= 1'b1;
        end else begin
            sync1      <= keypad;
            ks         <= sync1;
            state      <= state_n;
            cand       <= cand_n;
            cnt        <= cnt_n;
            bcd_output <= bcd_n;
            loadn      <= loadn_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        bcd_n   = bcd_output;
        unique case (state)
            IDLE: begin
                if (!enablen && onehot_valid(ks)) begin
                    cand_n  = ks;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (ks != cand || enablen) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = LOAD;
                    bcd_n   = encode(cand);
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            LOAD: state_n = WAIT_RELEASE;
            WAIT_RELEASE: begin
                if (ks == '0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Registered so the strobe falls on the same edge bcd_output updates.
        loadn_n = (state_n != LOAD);
    end

    clk_divider #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .pgt_1hz(pgt_1hz)
    );

endmodule

// File: tb/tb_keypad_encoder.sv
// Randomized bench for keypad_encoder against a streak-counting model.
// Directed scenarios pin latency, values and the timebase.
module tb_keypad_encoder;

    localparam int DC = 4;
    localparam int HP = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] keypad = '0;
    logic       enablen = 1'b0;
    logic [3:0] bcd_output;
    logic       loadn;
    logic       pgt_1hz;

    keypad_encoder #(
        .DEBOUNCE_CYCLES(DC),
        .HALF_PERIOD    (HP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keypad    (keypad),
        .enablen   (enablen),
        .bcd_output(bcd_output),
        .loadn     (loadn),
        .pgt_1hz   (pgt_1hz)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: counts consecutive identical samples of the
    // synchronized key; DC+1 of them (capture plus DC checks) load it.
    int         cyc = 0;
    bit         started = 0;
    logic [9:0] h1, h2, mks;
    int         m_streak, div_n;
    bit         m_skip, m_wait;
    logic [9:0] m_key;
    int         exp_bcd;
    int         exp_loadn;

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (rst) begin
            h1 = '0; h2 = '0;
            m_streak = 0; m_skip = 0; m_wait = 0; m_key = '0;
            exp_bcd = 0; exp_loadn = 1; div_n = 0;
        end else begin
            mks = h2;
            exp_loadn = 1;
            if (m_skip) begin
                m_skip = 0;
                m_wait = 1;
            end else if (m_wait) begin
                if (mks == 0) m_wait = 0;
            end else if (m_streak == 0) begin
                if (!enablen && $countones(mks) == 1) begin
                    m_key = mks;
                    m_streak = 1;
                end
            end else if (mks != m_key || enablen) begin
                m_streak = 0;
            end else begin
                m_streak++;
                if (m_streak == DC + 1) begin
                    exp_loadn = 0;
                    exp_bcd = $clog2(m_key);
                    m_streak = 0;
                    m_skip = 1;
                end
            end
            h2 = h1;
            h1 = keypad;
            div_n++;
        end
    end

    int   pulses = 0;
    int   low_cyc = -1;
    int   rises = 0;
    logic prev_pgt = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            chk("bcd_output", int'(bcd_output), exp_bcd);
            chk("loadn", int'(loadn), exp_loadn);
            chk("pgt_1hz", int'(pgt_1hz), (div_n / HP) % 2);
            if (loadn === 1'b0) begin
                pulses++;
                low_cyc = cyc;
            end
            if (pgt_1hz === 1'b1 && prev_pgt === 1'b0) rises++;
            prev_pgt = pgt_1hz;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [9:0] onehot(input int i);
        logic [9:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    int p0, press_cyc, r0, k1, k2, waited;

    initial begin
        tick(3);
        chk("reset_bcd", int'(bcd_output), 0);
        chk("reset_loadn", int'(loadn), 1);
        chk("reset_pgt", int'(pgt_1hz), 0);
        rst = 1'b0;

        p0 = pulses;
        press_cyc = cyc;
        keypad = 10'b0000000100;
        tick(500);
        chk("key2_pulses", pulses - p0, 1);
        chk("key2_bcd", int'(bcd_output), 2);
        chk("key2_latency", low_cyc - press_cyc, DC + 3);

        keypad = '0; tick(10);
        keypad = 10'b1000000000; tick(20);
        chk("key9_bcd", int'(bcd_output), 9);
        keypad = '0; tick(10);
        keypad = 10'b0000000001; tick(20);
        chk("key0_bcd", int'(bcd_output), 0);
        keypad = '0; tick(10);

        p0 = pulses;
        keypad = 10'b0000010010; tick(50);
        chk("twokey_pulses", pulses - p0, 0);
        chk("twokey_bcd", int'(bcd_output), 0);
        keypad = '0; tick(10);

        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            keypad = onehot(5); tick(2);
            keypad = '0; tick(2);
        end
        chk("bounce_pulses", pulses - p0, 0);
        keypad = onehot(5); tick(20);
        chk("key5_pulses", pulses - p0, 1);
        chk("key5_bcd", int'(bcd_output), 5);
        keypad = '0; tick(10);

        p0 = pulses;
        enablen = 1'b1;
        keypad = onehot(7); tick(30);
        chk("disabled_pulses", pulses - p0, 0);
        enablen = 1'b0; tick(20);
        chk("key7_pulses", pulses - p0, 1);
        chk("key7_bcd", int'(bcd_output), 7);
        keypad = '0; tick(10);

        r0 = rises;
        for (int s = 0; s < 500; ) begin
            int len, sel;
            len = $urandom_range(1, 12);
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                keypad = onehot($urandom_range(0, 9));
            end else if (sel < 8) begin
                keypad = '0;
            end else begin
                k1 = $urandom_range(0, 9);
                k2 = (k1 + $urandom_range(1, 9)) % 10;
                keypad = onehot(k1) | onehot(k2);
            end
            enablen = ($urandom_range(0, 7) == 0);
            if (s + len > 500) len = 500 - s;
            tick(len);
            s += len;
        end
        chk("pgt_rises_500", rises - r0, 5);

        for (int s = 0; s < 2500; ) begin
            int len;
            len = $urandom_range(1, 14);
            keypad = ($urandom_range(0, 3) == 0) ? '0 :
                     onehot($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) keypad = keypad | onehot(3);
            enablen = ($urandom_range(0, 9) == 0);
            tick(len);
            s += len;
        end

        keypad = '0; enablen = 1'b0; tick(10);
        keypad = onehot(3);
        waited = 0;
        while (loadn !== 1'b0 && waited < 50) begin
            tick(1);
            waited++;
        end
        if (waited >= 50) begin
            errors++;
            $display("FAIL load_timeout: got no strobe expected one");
        end
        rst = 1'b1; tick(1);
        chk("rst_in_load_loadn", int'(loadn), 1);
        chk("rst_in_load_bcd", int'(bcd_output), 0);
        rst = 1'b0; keypad = '0; tick(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
